// File: rtl/soc_io_bridge.sv
// Memory-port bridge for the core: RAM/IO address decode, read-data return mux,
// and the IO register block (LEDs, synchronised switches, 8N1 UART transmitter).
module soc_io_bridge #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int IO_BIT      = 22,
  parameter int NLED        = 10,
  parameter int NSW         = 10
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     cpu_addr_i,
  input  logic            cpu_rstrb_i,
  input  logic [31:0]     cpu_wdata_i,
  input  logic [3:0]      cpu_wmask_i,
  output logic [31:0]     cpu_rdata_o,
  output logic            ram_rstrb_o,
  output logic [3:0]      ram_wmask_o,
  input  logic [31:0]     ram_rdata_i,
  output logic [NLED-1:0] leds_o,
  input  logic [NSW-1:0]  sw_i,
  output logic            uart_tx_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  tx_state_e      state_q, state_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [NLED-1:0] leds_q;
  logic [NSW-1:0] sw_s1_q, sw_s2_q;
  logic           sel_io_q;
  logic [31:0]    io_rdata_q;
  logic [31:0]    io_val;
  logic           tx_line;

  logic       is_io, io_wr, tx_busy, tx_start, baud_done;
  logic [1:0] idx;
  logic       unused_ok;

  assign is_io     = cpu_addr_i[IO_BIT];
  assign idx       = cpu_addr_i[3:2];
  assign io_wr     = is_io & cpu_wmask_i[0];
  assign tx_busy   = (state_q != S_IDLE);
  assign tx_start  = io_wr & (idx == 2'd2) & ~tx_busy;
  assign baud_done = (baud_q == BAUD_LAST);
  assign unused_ok = ^{cpu_addr_i, cpu_wdata_i, cpu_wmask_i};

  assign ram_rstrb_o = cpu_rstrb_i & ~is_io;
  assign ram_wmask_o = cpu_wmask_i & {4{~is_io}};
  assign cpu_rdata_o = sel_io_q ? io_rdata_q : ram_rdata_i;
  assign leds_o      = leds_q;
  assign uart_tx_o   = tx_line;

  always_comb begin
    io_val = '0;
    case (idx)
      2'd0:    io_val[NLED-1:0] = leds_q;
      2'd1:    io_val[NSW-1:0]  = sw_s2_q;
      2'd3:    io_val[0]        = tx_busy;
      default: io_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      leds_q     <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      sel_io_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      sw_s1_q <= sw_i;
      sw_s2_q <= sw_s1_q;
      if (io_wr && idx == 2'd0) leds_q <= cpu_wdata_i[NLED-1:0];
      // IO data is captured at the strobe so it lines up with RAM's one-cycle latency
      if (cpu_rstrb_i) begin
        sel_io_q <= is_io;
        if (is_io) io_rdata_q <= io_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_line = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d = cpu_wdata_i[7:0];
          bit_d   = '0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else baud_d = baud_q + 1'b1;
      end
      S_DATA: begin
        tx_line = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else baud_d = baud_q + 1'b1;
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_io_bridge.sv
// Bench for soc_io_bridge: reset checks, a vector table of register accesses,
// directed UART frame sequences and a randomized run against a cycle-level model.
module tb_soc_io_bridge;
  localparam int CPB = 4;
  localparam logic [31:0] IO = 32'h0040_0000;
  localparam logic [31:0] LEDA = IO + 32'h0, SWA = IO + 32'h4, TXA = IO + 32'h8, STA = IO + 32'hC;

  logic        clk = 1'b0, resetn = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, ram_rdata = 32'hCAFE_BABE;
  logic        cpu_rstrb = 1'b0;
  logic [3:0]  cpu_wmask = '0;
  logic [31:0] cpu_rdata;
  logic        ram_rstrb, uart_tx;
  logic [3:0]  ram_wmask;
  logic [9:0]  leds, sw = '0;

  int ntests = 0, nfail = 0;

  soc_io_bridge #(.CLK_FREQ_HZ(400), .BAUD(100), .IO_BIT(22), .NLED(10), .NSW(10)) dut (
    .clk(clk), .resetn(resetn), .cpu_addr_i(cpu_addr), .cpu_rstrb_i(cpu_rstrb),
    .cpu_wdata_i(cpu_wdata), .cpu_wmask_i(cpu_wmask), .cpu_rdata_o(cpu_rdata),
    .ram_rstrb_o(ram_rstrb), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata),
    .leds_o(leds), .sw_i(sw), .uart_tx_o(uart_tx));

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's access just after the rising edge.
  task automatic cyc(input logic [31:0] a, input logic r, input logic [31:0] wd, input logic [3:0] wm);
    @(posedge clk); #1;
    cpu_addr = a; cpu_rstrb = r; cpu_wdata = wd; cpu_wmask = wm;
  endtask

  task automatic idle();
    cyc(32'h0, 1'b0, 32'h0, 4'h0);
  endtask

  // Expected line level at cycle offset o (0..10*CPB-1) into a frame.
  function automatic logic exp_tx(input logic [7:0] d, input int o);
    int b;
    b = o / CPB;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return 1'b1;
  endfunction

  typedef struct {
    logic [31:0] addr; logic rd; logic [31:0] wd; logic [3:0] wm;
    logic [31:0] exp_rd; logic [9:0] exp_leds; logic exp_rrs; logic [3:0] exp_rwm;
  } vec_t;
  vec_t tbl[12];

  // Randomized-run model state
  int          tx_k;
  logic [7:0]  tx_d;
  logic [9:0]  leds_m, sw_c1, sw_c2;
  logic        rd_io;
  logic [31:0] rd_val;

  function automatic logic busy_at(input int c);
    return (c >= tx_k + 1) && (c <= tx_k + 10*CPB);
  endfunction

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_leds", leds, 0);
    chk("reset_tx", uart_tx, 1);
    cyc(STA, 1, 0, 0); idle(); @(negedge clk);
    chk("reset_status", cpu_rdata, 0);

    sw = 10'h155;
    repeat (3) idle();

    tbl[0]  = '{LEDA,      0, 32'h0000_02A5, 4'hF, 32'h0,         10'h2A5, 0, 4'h0};
    tbl[1]  = '{LEDA,      1, 32'h0,         4'h0, 32'h0000_02A5, 10'h2A5, 0, 4'h0};
    tbl[2]  = '{LEDA,      0, 32'h0000_03FF, 4'h2, 32'h0,         10'h2A5, 0, 4'h0};
    tbl[3]  = '{LEDA,      0, 32'hFFFF_F0F0, 4'h1, 32'h0,         10'h0F0, 0, 4'h0};
    tbl[4]  = '{LEDA,      1, 32'h0,         4'h0, 32'h0000_00F0, 10'h0F0, 0, 4'h0};
    tbl[5]  = '{SWA,       1, 32'h0,         4'h0, 32'h0000_0155, 10'h0F0, 0, 4'h0};
    tbl[6]  = '{SWA,       0, 32'h0000_0001, 4'hF, 32'h0,         10'h0F0, 0, 4'h0};
    tbl[7]  = '{STA,       1, 32'h0,         4'h0, 32'h0,         10'h0F0, 0, 4'h0};
    tbl[8]  = '{TXA,       1, 32'h0,         4'h0, 32'h0,         10'h0F0, 0, 4'h0};
    tbl[9]  = '{32'h100,   1, 32'h0,         4'h0, 32'hCAFE_BABE, 10'h0F0, 1, 4'h0};
    tbl[10] = '{32'h104,   0, 32'h1234_5678, 4'h5, 32'h0,         10'h0F0, 0, 4'h5};
    tbl[11] = '{LEDA + 3,  1, 32'h0,         4'h0, 32'h0000_00F0, 10'h0F0, 0, 4'h0};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].addr, tbl[i].rd, tbl[i].wd, tbl[i].wm);
      @(negedge clk);
      chk($sformatf("vec%0d_ram_rstrb", i), ram_rstrb, tbl[i].exp_rrs);
      chk($sformatf("vec%0d_ram_wmask", i), ram_wmask, tbl[i].exp_rwm);
      idle(); @(negedge clk);
      chk($sformatf("vec%0d_leds", i), leds, tbl[i].exp_leds);
      if (tbl[i].rd) chk($sformatf("vec%0d_rdata", i), cpu_rdata, tbl[i].exp_rd);
    end

    // Frame 0x55 with STATUS polled every cycle
    cyc(TXA, 0, 32'h55, 4'h1);
    for (int i = 0; i <= 10*CPB + 1; i++) begin
      cyc(STA, 1, 0, 0); @(negedge clk);
      chk($sformatf("f55_tx%0d", i), uart_tx, (i < 10*CPB) ? exp_tx(8'h55, i) : 1'b1);
      if (i >= 1) chk($sformatf("f55_busy%0d", i), cpu_rdata, (i <= 10*CPB) ? 1 : 0);
    end
    idle();

    // Dropped mid-frame write, then back-to-back frame on the first idle cycle
    cyc(TXA, 0, 32'hA3, 4'h1);
    for (int i = 0; i < 10*CPB; i++) begin
      if (i == 14) cyc(TXA, 0, 32'hFF, 4'h1); else idle();
      @(negedge clk);
      chk($sformatf("fA3_tx%0d", i), uart_tx, exp_tx(8'hA3, i));
    end
    cyc(TXA, 0, 32'h3C, 4'h1); @(negedge clk);
    chk("b2b_idle_tx", uart_tx, 1);
    for (int i = 0; i < 10*CPB; i++) begin
      idle(); @(negedge clk);
      chk($sformatf("f3C_tx%0d", i), uart_tx, exp_tx(8'h3C, i));
    end

    // Reset during DATA aborts the frame
    cyc(TXA, 0, 32'h00, 4'h1);
    repeat (12) idle();
    @(negedge clk);
    chk("pre_rst_tx_low", uart_tx, 0);
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", uart_tx, 1);
    chk("rst_mid_leds", leds, 0);
    cyc(STA, 1, 0, 0); idle(); @(negedge clk);
    chk("rst_mid_busy", cpu_rdata, 0);
    cyc(TXA, 0, 32'h81, 4'h1);
    for (int i = 0; i < 10*CPB; i++) begin
      idle(); @(negedge clk);
      chk($sformatf("f81_tx%0d", i), uart_tx, exp_tx(8'h81, i));
    end

    // Randomized run against the cycle-level model
    @(posedge clk); #1 resetn = 1'b0; cpu_rstrb = 0; cpu_wmask = 0;
    tx_k = -1000; tx_d = 0; leds_m = 0; rd_io = 0; rd_val = 0;
    sw_c1 = 0; sw_c2 = 0;
    for (int c = 0; c < 1500; c++) begin
      int op;
      logic [31:0] a;
      logic [1:0] ix;
      logic io;
      @(posedge clk); #1;
      resetn = 1'b1;
      op = $urandom_range(0, 7);
      a = $urandom & ~32'h0040_0000;
      if (op >= 2 && op <= 5) a = a | IO;
      if (op == 4) a = (a & ~32'hC) | 32'h8;
      if (op == 5) a = a | 32'hC;
      cpu_addr = a;
      cpu_rstrb = (op == 2 || op == 5 || op == 6);
      cpu_wdata = $urandom;
      cpu_wmask = (op == 3) ? 4'($urandom) : (op == 4) ? 4'h1 : (op == 7) ? 4'($urandom_range(1, 15)) : 4'h0;
      ram_rdata = $urandom;
      if ($urandom_range(0, 9) == 0) sw = 10'($urandom);
      io = a[22]; ix = a[3:2];
      @(negedge clk);
      chk("rnd_ram_rstrb", ram_rstrb, cpu_rstrb & ~io);
      chk("rnd_ram_wmask", ram_wmask, io ? 4'h0 : cpu_wmask);
      chk("rnd_leds", leds, leds_m);
      chk("rnd_rdata", cpu_rdata, rd_io ? rd_val : ram_rdata);
      chk("rnd_tx", uart_tx, (c - tx_k - 1 >= 0 && c - tx_k - 1 < 10*CPB) ? exp_tx(tx_d, c - tx_k - 1) : 1'b1);
      if (cpu_rstrb) begin
        rd_io = io;
        if (io) begin
          case (ix)
            2'd0: rd_val = 32'(leds_m);
            2'd1: rd_val = 32'(sw_c2);
            2'd2: rd_val = 0;
            default: rd_val = 32'(busy_at(c));
          endcase
        end
      end
      if (io && cpu_wmask[0] && ix == 2'd0) leds_m = cpu_wdata[9:0];
      if (io && cpu_wmask[0] && ix == 2'd2 && !busy_at(c)) begin
        tx_k = c; tx_d = cpu_wdata[7:0];
      end
      sw_c2 = sw_c1; sw_c1 = sw;
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
